// File: rtl/median_frame_sequencer.sv
// Frame controller for the 3x3 median filter: loads one column-major
// frame, steps the filter per pixel and streams the results back out.
module median_frame_sequencer #(
  parameter int WIDTH = 1080,
  parameter int DEPTH = 1080,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_last,
  output logic             flt_clear,
  output logic             flt_enable,
  output logic [PIX_W-1:0] flt_pixel,
  output logic             flt_enable_process,
  input  logic [PIX_W-1:0] flt_result,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             frame_err
);

  localparam int N = WIDTH * DEPTH;
  localparam logic [31:0] LAST = 32'(N - 1);
  localparam logic [31:0] NCNT = 32'(N);

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD, PROCESS, DRAIN, DONE
  } state_t;

  state_t      state;
  logic [31:0] in_cnt;
  logic [31:0] out_cnt;
  logic        pend;
  logic        s_hs;
  logic        m_hs;
  logic        issue;

  assign s_hs  = s_valid && s_ready;
  assign m_hs  = m_valid && m_ready;
  assign issue = (state == PROCESS) && !pend
              && (!m_valid || m_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      in_cnt             <= '0;
      out_cnt            <= '0;
      pend               <= 1'b0;
      s_ready            <= 1'b0;
      flt_clear          <= 1'b0;
      flt_enable         <= 1'b0;
      flt_pixel          <= '0;
      flt_enable_process <= 1'b0;
      m_valid            <= 1'b0;
      m_data             <= '0;
      m_last             <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      frame_err          <= 1'b0;
    end else begin
      flt_clear          <= 1'b0;
      flt_enable         <= 1'b0;
      flt_enable_process <= 1'b0;
      done               <= 1'b0;
      frame_err          <= 1'b0;
      // Result capture has priority over retiring the held pixel.
      if (pend) begin
        m_data  <= flt_result;
        m_valid <= 1'b1;
        m_last  <= (out_cnt == NCNT);
        pend    <= 1'b0;
      end else if (m_hs) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= CLEAR;
            flt_clear <= 1'b1;
            busy      <= 1'b1;
          end
        end
        CLEAR: begin
          in_cnt  <= '0;
          out_cnt <= '0;
          s_ready <= 1'b1;
          state   <= LOAD;
        end
        LOAD: begin
          if (s_hs) begin
            flt_enable <= 1'b1;
            flt_pixel  <= s_data;
            in_cnt     <= in_cnt + 32'd1;
            if (in_cnt == LAST) begin
              state     <= PROCESS;
              s_ready   <= 1'b0;
              frame_err <= !s_last;
            end else if (s_last) begin
              state     <= IDLE;
              s_ready   <= 1'b0;
              busy      <= 1'b0;
              frame_err <= 1'b1;
              flt_clear <= 1'b1;
            end
          end
        end
        PROCESS: begin
          if (issue) begin
            flt_enable_process <= 1'b1;
            pend               <= 1'b1;
            out_cnt            <= out_cnt + 32'd1;
            if (out_cnt == LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (m_hs && m_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median_frame_sequencer.sv
// Randomized bench: 4x4 frames, behavioural filter stub and a
// median-of-neighbourhood reference for every output pixel.
module tb_median_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       flt_clear;
  logic       flt_enable;
  logic [7:0] flt_pixel;
  logic       flt_enable_process;
  logic [7:0] flt_result;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;
  logic       done;
  logic       frame_err;

  median_frame_sequencer #(
    .WIDTH(4), .DEPTH(4), .PIX_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .flt_clear(flt_clear), .flt_enable(flt_enable),
    .flt_pixel(flt_pixel),
    .flt_enable_process(flt_enable_process),
    .flt_result(flt_result),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] med9(
    input logic [7:0] img [16], input int p);
    logic [7:0] v [9];
    logic [7:0] t;
    int c, r, k;
    k = 0;
    for (int dc = -1; dc <= 1; dc++)
      for (int dr = -1; dr <= 1; dr++) begin
        c = p / 4 + dc;
        r = p % 4 + dr;
        if (c >= 0 && c < 4 && r >= 0 && r < 4)
          v[k] = img[c * 4 + r];
        else
          v[k] = 8'd0;
        k++;
      end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j + 1]) begin
          t = v[j]; v[j] = v[j + 1]; v[j + 1] = t;
        end
    return v[4];
  endfunction

  logic [7:0] sent [16];
  logic [7:0] got_out [16];
  logic [7:0] ld [16];
  int ld_idx, step_idx;

  // Filter stand-in: captures loads, answers with the step's median.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_idx   <= 0;
      step_idx <= 0;
    end else begin
      if (flt_clear) begin
        ld_idx   <= 0;
        step_idx <= 0;
      end
      if (flt_enable) begin
        ld[ld_idx % 16] <= flt_pixel;
        ld_idx <= ld_idx + 1;
      end
      if (flt_enable_process) step_idx <= step_idx + 1;
    end
  end

  always @(negedge clk)
    flt_result <= flt_enable_process ?
                  med9(ld, step_idx % 16) : 8'd0;

  int en_n, step_n, out_n, done_n, ferr_n, clr_n, last_n;
  logic hold;
  logic [7:0] hold_d;

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (flt_enable) begin
        check("load_pix", 32'(flt_pixel), 32'(sent[en_n % 16]));
        en_n++;
      end
      if (flt_enable || flt_enable_process)
        check("en_excl", 32'(flt_enable && flt_enable_process), 0);
      if (flt_enable_process) step_n++;
      if (done) done_n++;
      if (frame_err) ferr_n++;
      if (flt_clear) clr_n++;
      if (hold) begin
        check("stall_valid", 32'(m_valid), 1);
        check("stall_data", 32'(m_data), 32'(hold_d));
      end
      if (m_valid && m_ready) begin
        check("m_data", 32'(m_data), 32'(med9(sent, out_n % 16)));
        check("m_last", 32'(m_last), 32'(out_n == 15));
        got_out[out_n % 16] = m_data;
        if (m_last) last_n++;
        out_n++;
      end
      hold   = m_valid && !m_ready;
      hold_d = m_data;
    end
  end

  int rdy_mode = 0;
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_ready = (rdy_mode == 1) ? 1'b1 :
                (rdy_mode == 2) ? 1'b0 :
                ($urandom_range(0, 2) != 0);
    end
  end

  task automatic zero_cnts();
    en_n = 0; step_n = 0; out_n = 0; done_n = 0;
    ferr_n = 0; clr_n = 0; last_n = 0;
  endtask

  task automatic frame(input int kind, input int len,
                       input int last_at);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < len; i++) begin
      int t;
      logic [7:0] d;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      d = (kind == 1) ? 8'd50 : 8'($urandom);
      sent[i] = d;
      s_data  = d;
      s_valid = 1'b1;
      s_last  = (i == last_at);
      t = 0;
      @(negedge clk);
      while (!s_ready && t < 100) begin
        @(negedge clk); t++;
      end
      if (!s_ready) begin
        check("s_ready_timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        break;
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_n == 0 && t < 3000) begin
      @(negedge clk); t++;
    end
    check("done_seen", 32'(done_n != 0), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic post_ok(input int ferr_exp);
    check("n_en", 32'(en_n), 16);
    check("n_out", 32'(out_n), 16);
    check("n_last", 32'(last_n), 1);
    check("n_done", 32'(done_n), 1);
    check("n_ferr", 32'(ferr_n), 32'(ferr_exp));
    check("busy_end", 32'(busy), 0);
  endtask

  function automatic logic [31:0] outs();
    return 32'({s_ready, flt_clear, flt_enable, flt_pixel,
                flt_enable_process, m_valid, m_data, m_last,
                busy, done, frame_err});
  endfunction

  initial begin
    int t;
    int s0;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0;
    s_data = '0; s_last = 1'b0;
    zero_cnts();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", outs(), 0);
    rst = 1'b0;

    for (int f = 0; f < 2; f++) begin
      zero_cnts();
      frame(0, 16, 15);
      wait_done();
      post_ok(0);
    end

    rdy_mode = 1;
    zero_cnts();
    frame(1, 16, 15);
    wait_done();
    post_ok(0);
    check("corner0", 32'(got_out[0]), 0);
    check("edge1", 32'(got_out[1]), 50);
    check("inner5", 32'(got_out[5]), 50);
    check("corner15", 32'(got_out[15]), 0);
    rdy_mode = 0;

    rdy_mode = 2;
    zero_cnts();
    frame(0, 16, 15);
    t = 0;
    while (!m_valid && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check("stall_mvalid", 32'(m_valid), 1);
    s0 = step_n;
    repeat (10) @(posedge clk);
    #1;
    check("stall_steps", 32'(step_n - s0 <= 1), 1);
    check("stall_nout", 32'(out_n), 0);
    rdy_mode = 0;
    wait_done();
    post_ok(0);

    zero_cnts();
    frame(0, 5, 4);
    repeat (5) @(posedge clk);
    #1;
    check("drop_ferr", 32'(ferr_n), 1);
    check("drop_clear", 32'(clr_n), 2);
    check("drop_busy", 32'(busy), 0);
    check("drop_nout", 32'(out_n), 0);
    check("drop_done", 32'(done_n), 0);

    zero_cnts();
    frame(0, 16, -1);
    wait_done();
    post_ok(1);

    zero_cnts();
    frame(0, 6, -1);
    rst = 1'b1;
    #1;
    check("rst_load", outs(), 0);
    @(posedge clk); #1 rst = 1'b0;

    zero_cnts();
    frame(0, 16, 15);
    t = 0;
    while (out_n < 3 && t < 500) begin
      @(negedge clk); t++;
    end
    check("mid_outs", 32'(out_n >= 3), 1);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("rst_proc", outs(), 0);
    @(posedge clk); #1 rst = 1'b0;

    zero_cnts();
    frame(0, 16, 15);
    wait_done();
    post_ok(0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
